// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: a - b - bin through one full-subtractor cell, LSB first.
// Operands are captured on start; the result and a one-cycle done pulse follow WIDTH cycles later.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic             br;
  logic             a_msb;
  logic             b_msb;
  logic [CNT_W-1:0] cnt;

  // The shared full-subtractor cell.
  logic cell_d;
  logic cell_nb;
  assign cell_d  = sa[0] ^ sb[0] ^ br;
  assign cell_nb = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      br    <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            br    <= bin;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sr <= {cell_d, sr[WIDTH-1:1]};
          sa <= {1'b0, sa[WIDTH-1:1]};
          sb <= {1'b0, sb[WIDTH-1:1]};
          br <= cell_nb;
          if (cnt == LAST_BIT) begin
            // Overflow: operand signs differ and the result sign departs from the minuend.
            diff  <= {cell_d, sr[WIDTH-1:1]};
            bout  <= cell_nb;
            ovf   <= (a_msb ^ b_msb) & (cell_d ^ a_msb);
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
